mnist_frame_ctrl: RTL

MNIST_FRAME_CTRL -- requirements
Module: mnist_frame_ctrl

---
 rtl/mnist_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mnist_frame_ctrl.sv
// MNIST frame controller: receives SYNC-delimited pixel frames from UART RX, feeds the core,
// and replies with class and latency. Define FRAME_CHKSUM_EN to add an XOR checksum byte.
module mnist_frame_ctrl #(
  parameter int         PIXELS      = 784,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         RES_W       = 32,
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         UART_BPS    = 115200,
  parameter int         TIMEOUT_CYC = 5_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  input  logic [RES_W-1:0] res_in,
  input  logic             res_valid,
  output logic [7:0]       tx_data,
  output logic             tx_flag,
  output logic [3:0]       display_num,
  output logic             frame_err,
  output logic [7:0]       err_cnt
);

`ifdef FRAME_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int GAP    = (CLK_FREQ / UART_BPS) * 11;
  localparam int NBYTES = CHK_EN ? 7 : 6;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(PIXELS - 1);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);
  localparam logic [2:0]       NBYTES_L   = 3'(NBYTES);

  typedef enum logic [2:0] {S_IDLE, S_PIX, S_CHK, S_WAIT_RES, S_REPLY} state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [TO_W-1:0]  gap_q, gap_d;
  logic [31:0]      lat_q, lat_d, res_lat_q, res_lat_d;
  logic             lat_run_q, lat_run_d;
  logic [7:0]       rx_xor_q, rx_xor_d, tx_xor_q, tx_xor_d;
  logic             good_q, good_d;
  logic [3:0]       cls_q, cls_d, disp_q, disp_d;
  logic [7:0]       err_q, err_d;
  logic [GAP_W-1:0] tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       pix_data_q, pix_data_d, tx_data_q, tx_data_d;
  logic             pix_valid_q, pix_valid_d, tx_flag_q, tx_flag_d;
  logic             frame_err_q, frame_err_d;
  logic             err_event;
  logic [7:0]       reply_byte;
  logic             unused_res;

  // Only the class nibble of the core result is consumed.
  assign unused_res = ^res_in;

  always_comb begin
    case (idx_q)
      3'd0:    reply_byte = SYNC_BYTE;
      3'd1:    reply_byte = good_q ? {4'h0, cls_q} : 8'hEE;
      3'd2:    reply_byte = res_lat_q[31:24];
      3'd3:    reply_byte = res_lat_q[23:16];
      3'd4:    reply_byte = res_lat_q[15:8];
      3'd5:    reply_byte = res_lat_q[7:0];
      default: reply_byte = tx_xor_q;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    gap_d       = gap_q;
    lat_d       = lat_q;
    lat_run_d   = lat_run_q;
    res_lat_d   = res_lat_q;
    rx_xor_d    = rx_xor_q;
    tx_xor_d    = tx_xor_q;
    good_d      = good_q;
    cls_d       = cls_q;
    disp_d      = disp_q;
    err_d       = err_q;
    tmr_d       = tmr_q;
    idx_d       = idx_q;
    pix_data_d  = pix_data_q;
    tx_data_d   = tx_data_q;
    pix_valid_d = 1'b0;
    tx_flag_d   = 1'b0;
    frame_err_d = 1'b0;
    err_event   = 1'b0;

    if (lat_run_q && (lat_q != '1)) lat_d = lat_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d   = S_PIX;
          pix_cnt_d = '0;
          gap_d     = '0;
          rx_xor_d  = '0;
          good_d    = 1'b1;
        end
      end
      S_PIX: begin
        if (rx_valid) begin
          gap_d       = '0;
          pix_data_d  = rx_data;
          pix_valid_d = 1'b1;
          rx_xor_d    = rx_xor_q ^ rx_data;
          if (pix_cnt_q == '0) begin
            lat_d     = '0;
            lat_run_d = 1'b1;
          end
          if (pix_cnt_q == LAST_PIX) begin
            state_d   = CHK_EN ? S_CHK : S_WAIT_RES;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end else if (gap_q == TO_MAX) begin
          err_event = 1'b1;
          lat_run_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_CHK: begin
        if (!CHK_EN) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          if (rx_data != rx_xor_q) begin
            err_event = 1'b1;
            good_d    = 1'b0;
          end
          state_d = S_WAIT_RES;
        end else if (gap_q == TO_MAX) begin
          err_event = 1'b1;
          lat_run_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          cls_d     = res_in[3:0];
          res_lat_d = lat_q;
          lat_run_d = 1'b0;
          if (good_q) disp_d = res_in[3:0];
          tmr_d    = '0;
          idx_d    = '0;
          tx_xor_d = '0;
          state_d  = S_REPLY;
        end
      end
      S_REPLY: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (idx_q == NBYTES_L) begin
          state_d = S_IDLE;
        end else begin
          tx_data_d = reply_byte;
          tx_flag_d = 1'b1;
          tx_xor_d  = tx_xor_q ^ reply_byte;
          idx_d     = idx_q + 1'b1;
          tmr_d     = GAP_RELOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_event) begin
      frame_err_d = 1'b1;
      if (err_q != 8'hFF) err_d = err_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      gap_q       <= '0;
      lat_q       <= '0;
      lat_run_q   <= 1'b0;
      res_lat_q   <= '0;
      rx_xor_q    <= '0;
      tx_xor_q    <= '0;
      good_q      <= 1'b0;
      cls_q       <= '0;
      disp_q      <= '0;
      err_q       <= '0;
      tmr_q       <= '0;
      idx_q       <= '0;
      pix_data_q  <= '0;
      tx_data_q   <= '0;
      pix_valid_q <= 1'b0;
      tx_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      gap_q       <= gap_d;
      lat_q       <= lat_d;
      lat_run_q   <= lat_run_d;
      res_lat_q   <= res_lat_d;
      rx_xor_q    <= rx_xor_d;
      tx_xor_q    <= tx_xor_d;
      good_q      <= good_d;
      cls_q       <= cls_d;
      disp_q      <= disp_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      pix_data_q  <= pix_data_d;
      tx_data_q   <= tx_data_d;
      pix_valid_q <= pix_valid_d;
      tx_flag_q   <= tx_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_flag     = tx_flag_q;
  assign display_num = disp_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_q;

endmodule
